// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle for WIDTH cycles, then a sign-fix cycle that writes HI/LO.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d, mag_b_q, mag_b_d, raw_a_q, raw_a_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic                 sgn_op;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   prod_fix;

  function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // acc = {partial product, remaining multiplier bits}; shifts right each step.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // acc = {partial remainder, dividend/quotient bits}; restoring shift-subtract.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;
    rem  = acc[2*WIDTH-1:WIDTH-1];
    diff = rem - {1'b0, d};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else              return {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  assign sgn_op   = ~md_op[0];
  assign abs_a    = abs_if(op_a, sgn_op);
  assign abs_b    = abs_if(op_b, sgn_op);
  assign prod_fix = neg_2w(acc_q, neg_res_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    raw_a_d   = raw_a_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              mag_a_d   = abs_a;
              mag_b_d   = abs_b;
              raw_a_d   = op_a;
              is_div_d  = md_op[1];
              neg_res_d = sgn_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              neg_rem_d = sgn_op & op_a[WIDTH-1];
              acc_d     = {{WIDTH{1'b0}}, (md_op[1] ? abs_a : abs_b)};
              cnt_d     = '0;
              state_d   = S_RUN;
            end
            3'd4:    hi_d = op_a;
            3'd5:    lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_step(acc_q, mag_b_q) : mul_step(acc_q, mag_a_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (mag_b_q == '0) begin
          // Divide by zero reports the dividend as issued, without sign fix.
          hi_d = raw_a_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
          lo_d = neg_w(acc_q[WIDTH-1:0], neg_res_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Datapath operand/accumulator registers carry no reset; they are loaded at accept.
  always_ff @(posedge clk) begin
    mag_a_q   <= mag_a_d;
    mag_b_q   <= mag_b_d;
    raw_a_q   <= raw_a_d;
    acc_q     <= acc_d;
    is_div_q  <= is_div_d;
    neg_res_q <= neg_res_d;
    neg_rem_q <= neg_rem_d;
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: latency, results, MT writes, busy-ignore and reset abort.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally inject ignored requests mid-flight, then check result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input bit inject, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (inject && n == 10) begin
        start = 1'b1; md_op = 3'd0; op_a = 32'h0000_0005; op_b = 32'h0000_0009;
      end
      if (inject && n == 11) begin
        md_op = 3'd4; op_a = 32'h0000_DEAD; op_b = 32'h1111_1111;
      end
      if (inject && n == 12) start = 1'b0;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    @(negedge clk);
    check({tag, "_done_once"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg");
    run_op(3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0015, 1'b0, "mult_negneg");
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
    run_op(3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_negb");
    run_op(3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, "divu");
    run_op(3'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0, "divu_zero");
    run_op(3'd2, 32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b0, "div_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");

    // MTHI / MTLO while idle
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; op_a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    md_op = 3'd5; op_a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi_hold", hi, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_done", {31'd0, done}, 32'd0);
    md_op = 3'd6; start = 1'b1; op_a = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'h1234_5678);
    check("nop_lo", lo, 32'h9ABC_DEF0);

    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, "divu_ignore");

    // Reset mid-operation aborts without a done pulse
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; op_a = 32'd5; op_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_lo_hold", lo, 32'h0);

    run_op(3'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
